// File: rtl/half_narrow_sender.sv
// half_narrow_sender: sends 32-bit words over a 16-bit bus, truncated (with overflow flag) or as low/high halfwords.
module half_narrow_sender #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InData,
  input  logic             InMode,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [15:0]      OutData,
  output logic             OutLast,
  output logic             OutOvf,
  output logic [CNT_W-1:0] OvfCount
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state, state_n;
  logic [15:0] hi, hi_n, data_n;
  logic last_n, ovf_n, fire, accept, trunc_ovf;
  assign OutValid = state != IDLE;
  assign fire = OutValid & OutReady;
  assign InReady = (state == IDLE) | (fire & OutLast);
  assign accept = InValid & InReady;
  // A truncated word fits only if bits 31:15 are a pure sign extension.
  assign trunc_ovf = ~(&InData[31:15]) & (|InData[31:15]);
  always_comb begin
    state_n = accept ? LO : fire ? (OutLast ? IDLE : HI) : state;
    data_n = accept ? InData[15:0] : (fire & ~OutLast) ? hi : OutData;
    last_n = accept ? ~InMode : fire ? ~OutLast : OutLast;
    ovf_n = accept ? ~InMode & trunc_ovf : fire ? 1'b0 : OutOvf;
    hi_n = (accept & InMode) ? InData[31:16] : hi;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      OutData <= '0;
      OutLast <= 1'b0;
      OutOvf <= 1'b0;
      hi <= '0;
      OvfCount <= '0;
    end else begin
      state <= state_n;
      OutData <= data_n;
      OutLast <= last_n;
      OutOvf <= ovf_n;
      hi <= hi_n;
      if (fire & OutOvf & ~(&OvfCount)) OvfCount <= OvfCount + CNT_W'(1);
    end
  end
endmodule

// File: doc/half_narrow_sender.md
Name: half_narrow_sender

Overview:
- Store-side counterpart of the 16-to-32 sign extender: accepts 32-bit words from the datapath and sends them over a 16-bit halfword bus.
- Truncate mode: sends one halfword and flags loss of information, i.e. whether the word was not the sign extension of its low 16 bits.
- Full mode: sends the word as two halfwords, low then high.
- Sits between the register file/ALU result path and the 16-bit data memory write port; valid/ready on both sides.

Parameters:
- CNT_W, 8, width of the saturating overflow event counter.

Ports:
- Clk  input  1  single clock, rising-edge.
- Reset  input  1  synchronous, active-high.
- InValid  input  1  upstream word valid.
- InReady  output  1  block can accept a word this cycle.
- InData  input  32  word to send.
- InMode  input  1  0 = truncate (one beat), 1 = full (two beats); sampled with InData.
- OutValid  output  1  halfword on OutData valid.
- OutReady  input  1  downstream accepts the current halfword.
- OutData  output  16  halfword.
- OutLast  output  1  current beat is the final beat of the word.
- OutOvf  output  1  truncate beat lost information; 0 on all full-mode beats.
- OvfCount  output  CNT_W  saturating count of truncate words with OutOvf=1.

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high (Reset).
- Reset values: state IDLE; OutValid=0, OutData=0, OutLast=0, OutOvf=0, OvfCount=0; InReady=1 in the cycle after Reset deasserts.
- Reset mid-word: an in-flight word, or a pending high half, is discarded with no further beats. OvfCount clears to 0.
- States:
  - IDLE: output register empty.
  - LO: a beat is held, and it is the only/last beat or the low half of a full word.
  - HI: high half held.
- InReady = (state==IDLE) | (OutValid & OutReady & OutLast). Combinational from state and OutReady only; never from InValid.
- Accept = InValid & InReady. On accept at edge N, beat 1 is registered and OutValid=1 from cycle N+1. Latency is 1 cycle; there is no combinational In-to-Out path.
- Truncate accept:
  - OutData=InData[15:0], OutLast=1, state LO.
  - OutOvf=1 iff InData[31:15] is not all-0 and not all-1.
- Full accept:
  - OutData=InData[15:0], OutLast=0, OutOvf=0, state LO.
  - InData[31:16] is stored in an internal high register.
- LO with OutLast=0 and OutReady: load the high register into OutData, set OutLast=1, go to HI.
- LO/HI with OutLast=1 and OutReady:
  - With a new accept in the same cycle, load the new word (back-to-back, no bubble).
  - Otherwise OutValid=0 and go to IDLE.
- OutValid=1 and !OutReady: OutData, OutLast and OutOvf hold stable. No new accept is possible because InReady=0.
- OvfCount increments by 1 on the cycle a truncate beat with OutOvf=1 is accepted downstream (OutValid & OutReady & OutOvf). It saturates at 2^CNT_W-1 and never wraps.
- Throughput: 1 word/cycle in truncate mode, 1 word/2 cycles in full mode, with OutReady held high.
- InMode for the next word may differ from the current one; it takes effect at that word's accept.
- Stable beats: X on InData when InValid=0 must not propagate to the outputs.

Test Plan:
- Reset then idle: assert Reset 2 cycles -> all outputs 0, InReady=1 the next cycle, OutValid stays 0 with InValid=0.
- Truncate, fits: InData=0xFFFF8000, InMode=0, OutReady=1 -> the next cycle OutData=0x8000, OutLast=1, OutOvf=0, OvfCount=0. Then InData=0x00007FFF -> 0x7FFF, OutOvf=0.
- Truncate, overflow, back-to-back: words 0x00018000, 0x12345678 on consecutive cycles, OutReady=1 -> beats 0x8000 then 0x5678 on consecutive cycles, both OutOvf=1, OvfCount=2, InReady constantly 1.
- Full mode with stall: InData=0xDEADBEEF, InMode=1; OutReady low for 3 cycles -> 0xBEEF/OutLast=0 held 3 cycles with InReady=0; OutReady high -> 0xDEAD/OutLast=1, then IDLE.
- Saturation: CNT_W=2, five overflowing truncate words (0x00010000) -> OvfCount 1,2,3,3,3.
- Reset mid-word: full word 0xCAFEF00D, assert Reset while 0xF00D is held with OutReady=0 -> the next cycle OutValid=0, 0xCAFE never appears, InReady=1 after release.
